// File: rtl/lsu_controller_if.sv
// Data-memory bus between lsu_controller (master) and an external memory (slave).
interface lsu_controller_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic              req;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;
    logic              ready;

    modport master (output req, we, be, addr, wd, input  rd, ready);
    modport slave  (input  req, we, be, addr, wd, output rd, ready);
endinterface

// File: rtl/lsu_controller.sv
// Load/store sequencer between the core data port and a ready-handshake data memory.
// Optional `LSU_TIMEOUT_EN adds a BUSY watchdog of TIMEOUT_CYCLES that aborts with err_o.
module lsu_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         core_req_i,
    input  logic         core_we_i,
    input  logic [2:0]   core_size_i,
    input  logic [31:0]  core_addr_i,
    input  logic [31:0]  core_wd_i,
    output logic [31:0]  core_rd_o,
    output logic         core_stall_o,
    output logic         err_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [3:0]   mem_be_o,
    output logic [31:0]  mem_addr_o,
    output logic [31:0]  mem_wd_o,
    input  logic [31:0]  mem_rd_i,
    input  logic         mem_ready_i
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned BE_W   = XLEN / 8;
    localparam int unsigned SIZE_W = 3;
`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [SIZE_W-1:0] size_q;
    logic [1:0]        off_q;
`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0]  cnt_q;
`endif

    logic              illegal_c;
    logic [BE_W-1:0]   be_c;
    logic [XLEN-1:0]   wd_c;

    // Request decode: legality, byte enables and lane-replicated store data.
    always_comb begin
        illegal_c = 1'b0;
        be_c      = '0;
        wd_c      = core_wd_i;
        case (core_size_i)
            3'd0, 3'd4: begin
                be_c = BE_W'(4'b0001 << core_addr_i[1:0]);
                wd_c = {4{core_wd_i[7:0]}};
            end
            3'd1, 3'd5: begin
                be_c      = core_addr_i[1] ? 4'b1100 : 4'b0011;
                wd_c      = {2{core_wd_i[15:0]}};
                illegal_c = core_addr_i[0];
            end
            3'd2: begin
                be_c      = 4'b1111;
                illegal_c = |core_addr_i[1:0];
            end
            default: illegal_c = 1'b1;
        endcase
    end

    // Lane select and sign/zero extension of the returned memory word.
    function automatic logic [XLEN-1:0] load_ext(input logic [SIZE_W-1:0] size,
                                                 input logic [1:0]        off,
                                                 input logic [XLEN-1:0]   word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (size)
            3'd0:    load_ext = {{24{b[7]}}, b};
            3'd4:    load_ext = {24'd0, b};
            3'd1:    load_ext = {{16{h[15]}}, h};
            3'd5:    load_ext = {16'd0, h};
            default: load_ext = word;
        endcase
    endfunction

    assign core_stall_o = ((state == IDLE) && core_req_i) || (state == BUSY);

    // Sequencer with registered memory-side and core-side outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            size_q     <= '0;
            off_q      <= '0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= '0;
            mem_addr_o <= '0;
            mem_wd_o   <= '0;
            core_rd_o  <= '0;
            err_o      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req_i) begin
                        if (illegal_c) begin
                            state     <= DONE;
                            err_o     <= 1'b1;
                            core_rd_o <= '0;
                        end else begin
                            state      <= BUSY;
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= core_we_i;
                            mem_be_o   <= be_c;
                            mem_addr_o <= core_addr_i;
                            mem_wd_o   <= wd_c;
                            size_q     <= core_size_i;
                            off_q      <= core_addr_i[1:0];
`ifdef LSU_TIMEOUT_EN
                            cnt_q      <= '0;
`endif
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready_i) begin
                        state     <= DONE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        mem_be_o  <= '0;
                        if (!mem_we_o) begin
                            core_rd_o <= load_ext(size_q, off_q, mem_rd_i);
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    // Ready in the limit cycle takes precedence over the abort.
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state     <= DONE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        mem_be_o  <= '0;
                        err_o     <= 1'b1;
                        core_rd_o <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_controller.sv
// Randomized scoreboard bench for lsu_controller with a byte-level memory reference model.
module tb_lsu_controller;

    localparam int unsigned TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'd0;
    logic [31:0] core_addr_i = 32'd0;
    logic [31:0] core_wd_i = 32'd0;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    lsu_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .err_o        (err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        err;
        logic [31:0] rd;
    } done_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    done_t exp_done[$];
    bus_t  exp_bus[$];
    int    checks = 0;
    int    errors = 0;

    logic [31:0] mem_arr [256];
    logic [31:0] ref_arr [256];
    logic [31:0] model_rd = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        if (sz[1:0] == 2'd0) return 1;
        if (sz[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    // Monitor: pops expectations when the DUT completes or presents a bus request.
    logic prev_req = 1'b0;
    bus_t cur;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (core_req_i && !core_stall_o) begin
                if (exp_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: err_o=%b core_rd_o=%h", err_o, core_rd_o);
                end else begin
                    done_t e;
                    e = exp_done.pop_front();
                    check("err_o", 32'(err_o), 32'(e.err));
                    check("core_rd_o", core_rd_o, e.rd);
                end
            end else begin
                check("err_outside_done", 32'(err_o), 32'd0);
            end
            if (mem_req_o) begin
                if (!prev_req) begin
                    if (exp_bus.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_req: addr=%h", mem_addr_o);
                    end else begin
                        cur = exp_bus.pop_front();
                    end
                end
                check("mem_addr", mem_addr_o, cur.addr);
                check("mem_we", 32'(mem_we_o), 32'(cur.we));
                check("mem_be", 32'(mem_be_o), 32'(cur.be));
                if (cur.we) check("mem_wd", mem_wd_o, cur.wd);
            end else begin
                check("idle_we_be", 32'({mem_we_o, mem_be_o}), 32'd0);
            end
        end
        prev_req = mem_req_o;
    end

    task automatic recover();
        rst_i = 1'b1; core_req_i = 1'b0; mem_ready_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_done.delete(); exp_bus.delete();
        model_rd = 32'd0;
    endtask

    // Issue one access: compute the expected outcome, then drive core and memory sides.
    task automatic issue(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input int delay);
        int          n, off, exp_stall, stall_cnt, busy_n;
        logic        legal, timed_out, done;
        logic [7:0]  idx;
        logic [31:0] val, rep;
        bus_t        b;
        done_t       d;

        n   = nbytes(sz);
        off = int'(addr[1:0]);
        idx = addr[9:2];
        legal = (sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && ((off % n) == 0);
`ifdef LSU_TIMEOUT_EN
        timed_out = legal && (delay >= int'(TO));
`else
        timed_out = 1'b0;
`endif
        if (!legal) begin
            model_rd = 32'd0;
            d = '{err: 1'b1, rd: 32'd0};
            exp_stall = 1;
        end else begin
            for (int i = 0; i < 4; i++) rep[8*i +: 8] = wd[8*(i % n) +: 8];
            b.addr = addr;
            b.we   = we;
            b.be   = 4'(((1 << n) - 1) << off);
            b.wd   = rep;
            exp_bus.push_back(b);
            if (timed_out) begin
                exp_stall = int'(TO) + 1;
                model_rd = 32'd0;
                d = '{err: 1'b1, rd: 32'd0};
            end else begin
                exp_stall = delay + 2;
                if (we) begin
                    for (int i = 0; i < n; i++) ref_arr[idx][8*(off+i) +: 8] = wd[8*i +: 8];
                end else begin
                    val = 32'd0;
                    for (int i = 0; i < n; i++) val[8*i +: 8] = ref_arr[idx][8*(off+i) +: 8];
                    if (!sz[2] && n < 4 && val[8*n-1])
                        for (int i = 8*n; i < 32; i++) val[i] = 1'b1;
                    model_rd = val;
                end
                d = '{err: 1'b0, rd: model_rd};
            end
        end
        exp_done.push_back(d);

        core_req_i = 1'b1; core_we_i = we; core_size_i = sz;
        core_addr_i = addr; core_wd_i = $urandom;
        core_wd_i = wd;
        stall_cnt = 0; busy_n = 0; done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk_i);
            if (!core_stall_o) begin
                done = 1'b1;
            end else begin
                stall_cnt++;
                if (mem_req_o) begin
                    busy_n++;
                    if (busy_n > delay) begin
                        mem_ready_i = 1'b1;
                        mem_rd_i    = mem_arr[mem_addr_o[9:2]];
                        if (mem_we_o)
                            for (int j = 0; j < 4; j++)
                                if (mem_be_o[j]) mem_arr[mem_addr_o[9:2]][8*j +: 8] = mem_wd_o[8*j +: 8];
                    end else begin
                        mem_ready_i = 1'b0;
                        mem_rd_i    = $urandom;
                    end
                end else begin
                    mem_ready_i = 1'($urandom);
                    mem_rd_i    = $urandom;
                end
            end
        end
        mem_ready_i = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL completion_wait: no DONE within 64 cycles for addr %h", addr);
            recover();
        end else begin
            check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
            @(posedge clk_i); #1;
            core_req_i = 1'b0;
        end
    endtask

    task automatic gap();
        int g;
        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) begin
            core_req_i = 1'b0;
            mem_ready_i = 1'($urandom);
            mem_rd_i = $urandom;
            @(posedge clk_i); #1;
        end
        mem_ready_i = 1'b0;
    endtask

    initial begin
        mem_ready_i = 1'b0;
        mem_rd_i = 32'd0;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = $urandom;
            ref_arr[i] = mem_arr[i];
        end
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_we_be", 32'({mem_we_o, mem_be_o}), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_wd", mem_wd_o, 32'd0);
        check("rst_core_rd", core_rd_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_stall", 32'(core_stall_o), 32'd0);

        mem_arr[8'h40] = 32'hDEADBEEF; ref_arr[8'h40] = 32'hDEADBEEF;
        issue(1'b0, 3'd2, 32'h100, 32'd0, 0);
        mem_arr[8'h40] = 32'h80FF0000; ref_arr[8'h40] = 32'h80FF0000;
        issue(1'b0, 3'd0, 32'h103, 32'd0, 0);
        issue(1'b0, 3'd4, 32'h103, 32'd0, 1);
        issue(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 2);
        issue(1'b0, 3'd2, 32'h101, 32'd0, 0);
        issue(1'b0, 3'd3, 32'h100, 32'd0, 0);
        issue(1'b0, 3'd5, 32'h206, 32'd0, 5);

        // Reset in the middle of a wait: request dropped, no completion produced.
        begin
            bus_t b;
            b = '{addr: 32'h10C, we: 1'b0, be: 4'b1111, wd: 32'd0};
            exp_bus.push_back(b);
            core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h10C;
            repeat (3) begin @(posedge clk_i); #1; end
            rst_i = 1'b1; core_req_i = 1'b0;
            @(posedge clk_i); #1;
            rst_i = 1'b0;
            model_rd = 32'd0;
            check("midrst_mem_req", 32'(mem_req_o), 32'd0);
            check("midrst_mem_be", 32'(mem_be_o), 32'd0);
            check("midrst_stall", 32'(core_stall_o), 32'd0);
            check("midrst_core_rd", core_rd_o, 32'd0);
            @(posedge clk_i); #1;
            check("midrst_err", 32'(err_o), 32'd0);
        end

`ifdef LSU_TIMEOUT_EN
        issue(1'b0, 3'd2, 32'h108, 32'd0, 1000);
        issue(1'b1, 3'd2, 32'h10C, 32'h55AA55AA, 3);
`endif

        for (int t = 0; t < 300; t++) begin
            logic [2:0]  sz;
            logic [31:0] addr;
            int          n;
            sz   = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 1023));
            n    = nbytes(sz);
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
            issue(1'($urandom), sz, addr, $urandom, $urandom_range(0, 6));
            gap();
        end

        repeat (3) @(posedge clk_i);
        #1;
        check("pending_done", 32'(exp_done.size()), 32'd0);
        check("pending_bus", 32'(exp_bus.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
